// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
// -----------------
// Data-memory stage that sits directly behind the pipelined RISC-V core.
// Stores are posted into a small in-order FIFO and drained one per cycle
// into a single-port word array. A drain only happens in a cycle where no
// load is using the array port. Loads are forwarded from the youngest
// matching buffered store, so the core always sees program-order data.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rset       in   synchronous active-high reset (buffer only, not the array)
//   dm_we      in   store request from the core
//   mem_re     in   load request; claims the array port this cycle
//   MEM_addr   in   word address for the load or store
//   MEM_wDATA  in   store data
//   sb_flush   in   (only with SB_FLUSH_EN) force draining, refuse new stores
//   MEM_rData  out  combinational load data
//   sb_stall   out  store cannot be taken this cycle; the core must hold it
//   sb_empty   out  buffer holds no entries
//   sb_count   out  number of buffered entries
//
// Optional feature macro: SB_FLUSH_EN adds the sb_flush input. Without it
// the buffer follows the base accept/drain rules only.

module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rset,
    input  logic                     dm_we,
    input  logic                     mem_re,
    input  logic [ADDR_W-1:0]        MEM_addr,
    input  logic [DATA_W-1:0]        MEM_wDATA,
`ifdef SB_FLUSH_EN
    input  logic                     sb_flush,
`endif
    output logic [DATA_W-1:0]        MEM_rData,
    output logic                     sb_stall,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Buffer storage and bookkeeping. Entry validity is derived from the
    // distance to head compared against count, so no per-entry valid bits.
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Backing array, deliberately left out of reset.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic full;
    logic empty;
    logic drain;
    logic accept;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  fwd_idx;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full buffer can still take a store in a cycle where it also drains,
    // because the freed slot is reused by the incoming entry.
`ifdef SB_FLUSH_EN
    assign drain  = !empty && (!mem_re || sb_flush);
    assign accept = dm_we && !sb_flush && (!full || drain);
`else
    assign drain  = !empty && !mem_re;
    assign accept = dm_we && (!full || drain);
`endif

    assign sb_stall = dm_we && !accept;
    assign sb_empty = empty;
    assign sb_count = count_q;

    // Forwarding search walks the live entries oldest to youngest, so the
    // last hit is the youngest store to that address. The entry draining this
    // cycle is still live here; the entry being enqueued is not yet.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[fwd_idx] == MEM_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign MEM_rData = fwd_hit ? fwd_data : mem_q[MEM_addr];

    // Pointer and occupancy next-state. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (accept) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (accept && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (drain && !accept) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset; count alone decides what is live.
    always_ff @(posedge clk) begin
        if (accept && !rset) begin
            addr_q[tail_q] <= MEM_addr;
            data_q[tail_q] <= MEM_wDATA;
        end
    end

    // A reset discards a drain that would otherwise land this cycle.
    always_ff @(posedge clk) begin
        if (drain && !rset) begin
            mem_q[addr_q[head_q]] <= data_q[head_q];
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Testbench for dmem_store_buffer: directed scenarios followed by random
// traffic, checked by a scoreboard against a queue-based reference model.

module tb_dmem_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rset;
    logic              dmWe;
    logic              memRe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;
    logic              sbStall;
    logic              sbEmpty;
    logic [2:0]        sbCount;
`ifdef SB_FLUSH_EN
    logic              sbFlush;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } entry_t;

    typedef struct {
        bit                isLoad;
        logic [DATA_W-1:0] data;
        logic              stall;
        logic [2:0]        count;
        logic              empty;
    } exp_t;

    // Reference model: program-order store queue plus the memory image.
    entry_t            refQ[$];
    logic [DATA_W-1:0] refMem [2**ADDR_W];
    exp_t              expQ[$];

    dmem_store_buffer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rset     (rset),
        .dm_we    (dmWe),
        .mem_re   (memRe),
        .MEM_addr (memAddr),
        .MEM_wDATA(memWData),
`ifdef SB_FLUSH_EN
        .sb_flush (sbFlush),
`endif
        .MEM_rData(memRData),
        .sb_stall (sbStall),
        .sb_empty (sbEmpty),
        .sb_count (sbCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Youngest buffered store wins; otherwise the memory image.
    function automatic logic [DATA_W-1:0] refLoad(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = refMem[a];
        foreach (refQ[i]) begin
            if (refQ[i].a == a) r = refQ[i].d;
        end
        return r;
    endfunction

    // Drives one cycle of inputs, records what the DUT must show during this
    // cycle, then advances the model across the next clock edge.
    task automatic applyStimulus(input bit rst, input bit we, input bit re,
                                 input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d);
        exp_t   e;
        entry_t ent;
        bit     isFull, doDrain, doAccept;
        rset     = rst;
        dmWe     = we;
        memRe    = re;
        memAddr  = a;
        memWData = d;

        isFull   = (refQ.size() == DEPTH);
        doDrain  = (refQ.size() != 0) && !re;
        doAccept = we && (!isFull || doDrain);

        e.isLoad = re;
        e.data   = refLoad(a);
        e.stall  = we && !doAccept;
        e.count  = 3'(refQ.size());
        e.empty  = (refQ.size() == 0);
        expQ.push_back(e);

        if (rst) begin
            refQ.delete();
        end else begin
            if (doDrain) begin
                ent = refQ.pop_front();
                refMem[ent.a] = ent.d;
            end
            if (doAccept) begin
                ent.a = a;
                ent.d = d;
                refQ.push_back(ent);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compareOne(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareOne("sb_stall", 32'(sbStall), 32'(e.stall));
        compareOne("sb_count", 32'(sbCount), 32'(e.count));
        compareOne("sb_empty", 32'(sbEmpty), 32'(e.empty));
        if (e.isLoad) compareOne("MEM_rData", memRData, e.data);
    endtask

    // Monitor: one expectation per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, '0);
    endtask

    task automatic load(input logic [ADDR_W-1:0] a);
        applyStimulus(0, 0, 1, a, '0);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        rset     = 1'b1;
        dmWe     = 1'b0;
        memRe    = 1'b0;
        memAddr  = '0;
        memWData = '0;
`ifdef SB_FLUSH_EN
        sbFlush  = 1'b0;
`endif
        for (int i = 0; i < 2**ADDR_W; i++) refMem[i] = '0;
        @(posedge clk);
        #1;

        // Fill the whole array through the store path so the model is exact.
        for (int i = 0; i < 2**ADDR_W; i++) begin
            applyStimulus(0, 1, 0, 8'(i), (i == 'h10) ? 32'hA5A5A5A5 : $urandom);
        end
        idle(2);

        // Reset then idle, load preloaded word.
        applyStimulus(1, 0, 0, '0, '0);
        idle(1);
        load(8'h10);

        // Store-to-load forwarding while loads block the port.
        applyStimulus(0, 1, 0, 8'h20, 32'h11111111);
        load(8'h20);
        load(8'h20);
        idle(1);
        load(8'h20);

        // Duplicate addresses: youngest wins both in forwarding and in memory.
        applyStimulus(0, 1, 1, 8'h05, 32'h1);
        applyStimulus(0, 1, 1, 8'h05, 32'h2);
        load(8'h05);
        idle(3);
        load(8'h05);

        // Full and stall, then accept-while-draining at full.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 8'(i), 32'hC0DE0000 + 32'(i));
        applyStimulus(0, 1, 1, 8'h04, 32'hC0DE0004);
        applyStimulus(0, 1, 0, 8'h04, 32'hC0DE0004);
        idle(5);
        for (int i = 0; i < 5; i++) load(8'(i));

        // Wrap-around: stores interleaved with drains and blocking loads.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 1, 8'h40 + 8'($urandom_range(0, 7)), $urandom);
            if (i % 3 == 2) idle(1);
        end
        idle(6);
        for (int i = 0; i < 8; i++) load(8'h40 + 8'(i));

        // Reset with three entries buffered and a drain pending.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 8'h60 + 8'(i), 32'hDEAD0000 + 32'(i));
        applyStimulus(1, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) load(8'h60 + 8'(i));

        // Random traffic on a narrow address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            ra = 8'h70 + 8'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, ra, $urandom);
        end
        idle(6);
        for (int i = 0; i < 8; i++) load(8'h70 + 8'(i));

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
